// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: shares one burst-capable port among N requesters.
// A grant is held until the last beat of the burst is acknowledged. After that,
// the pointer moves to one past the winner, which gives burst-level fairness.
// Optional watchdog abort is enabled by defining the macro ARB_TIMEOUT_EN.
module rr_burst_scheduler #(
  parameter int unsigned N     = 4,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned TO_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_an,
  input  logic [N-1:0]         req,
  input  logic [N*LEN_W-1:0]   req_len,
  input  logic                 beat_ack,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned ID_W = $clog2(N);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     idx_sum;
  logic [LEN_W-1:0]  win_len;
  logic [ID_W-1:0]   ptr_next;
  logic              abort;
  logic              to_err;

  // Winner search: first requester at or above ptr, wrapping N-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx_sum   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx_sum >= (ID_W+1)'(N)) begin
        idx_sum = idx_sum - (ID_W+1)'(N);
      end
      if (!win_found && req[idx_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx_sum[ID_W-1:0];
      end
    end
  end

  assign win_len  = req_len[LEN_W*win_id +: LEN_W];
  assign ptr_next = (id_q == ID_W'(N - 1)) ? '0 : id_q + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  // Watchdog abort fires on the stalled cycle that brings the count to 2^TO_W-1.
  localparam logic [TO_W-1:0] WdLast = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] wd_q, wd_d;
  logic            to_err_q;

  // Watchdog next value: counts consecutive stalled busy cycles.
  always_comb begin
    abort = (state_q == StBusy) && !beat_ack && (wd_q == WdLast);
    wd_d  = '0;
    if ((state_q == StBusy) && !beat_ack && !abort) begin
      wd_d = wd_q + TO_W'(1);
    end
  end

  // Watchdog counter and one-cycle error pulse register.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= abort;
    end
  end

  assign to_err = to_err_q;
`else
  assign abort  = 1'b0;
  assign to_err = 1'b0;
`endif

  // State register plus pointer, grantee and remaining-beat counter.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant in idle, count beats (or abort) while busy.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
          id_d    = win_id;
          cnt_d   = win_len;
        end
      end
      StBusy: begin
        if (beat_ack) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
            ptr_d   = ptr_next;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end else if (abort) begin
          state_d = StIdle;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    grant = '0;
    if (state_q == StBusy) begin
      grant[id_q] = 1'b1;
    end
    busy        = (state_q == StBusy);
    grant_id    = id_q;
    timeout_err = to_err;
  end

endmodule
